// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the main-memory access sequencer.
// Holds the FSM state encoding and the default bus widths/timeout.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mac_state_e;

    localparam int MAC_DEF_DATAWIDTH_ADDR = 32;
    localparam int MAC_DEF_DATAWIDTH_DATA = 32;
    localparam int MAC_DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_access_ctrl_timeout_counter.sv
// Bounded-wait counter for the REQ state: clear on entry, count while
// waiting, saturate at TIMEOUT_CYCLES-1.
// Ports: clk_i, rst_i (sync, active-high), clear_i, enable_i, expired_o.
module mem_access_timeout_counter #(
    parameter int TIMEOUT_CYCLES    = 255,
    parameter int DATAWIDTH_TIMEOUT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [DATAWIDTH_TIMEOUT-1:0] LAST =
        DATAWIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [DATAWIDTH_TIMEOUT-1:0] cnt_q;
    logic [DATAWIDTH_TIMEOUT-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + DATAWIDTH_TIMEOUT'(1);
        end
    end

    // Pulse only in a waiting cycle that has reached the limit.
    assign expired_o = enable_i && (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: turns MIR RD/WR strobes into a held memory
// request, returns read data and a one-cycle ack (with err on timeout or
// illegal request).
// Ports: clock/reset, mac_* (control/datapath side), mem_* (memory side).
// Option: MEM_ACCESS_CTRL_ALIGN_CHECK_EN rejects non-word-aligned accesses.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATAWIDTH_ADDR    = MAC_DEF_DATAWIDTH_ADDR,
    parameter int DATAWIDTH_DATA    = MAC_DEF_DATAWIDTH_DATA,
    parameter int TIMEOUT_CYCLES    = MAC_DEF_TIMEOUT_CYCLES,
    parameter int DATAWIDTH_TIMEOUT = 8
) (
    input  logic                      MEM_ACCESS_CTRL_CLOCK_50,
    input  logic                      MEM_ACCESS_CTRL_RESET_InHigh,
    input  logic                      mac_rd,
    input  logic                      mac_wr,
    input  logic [DATAWIDTH_ADDR-1:0] mac_addr,
    input  logic [DATAWIDTH_DATA-1:0] mac_wdata,
    output logic                      mac_ack,
    output logic                      mac_err,
    output logic [DATAWIDTH_DATA-1:0] mac_rdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATAWIDTH_ADDR-1:0] mem_addr,
    output logic [DATAWIDTH_DATA-1:0] mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATAWIDTH_DATA-1:0] mem_rdata
);

    mac_state_e state_q, state_d;

    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic                      err_q, err_d;
    logic [DATAWIDTH_ADDR-1:0] addr_q, addr_d;
    logic [DATAWIDTH_DATA-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH_DATA-1:0] rdata_q, rdata_d;

    logic cnt_clr;
    logic cnt_en;
    logic expired;
    logic misaligned;

`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
    assign misaligned = (mac_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    mem_access_timeout_counter #(
        .TIMEOUT_CYCLES   (TIMEOUT_CYCLES),
        .DATAWIDTH_TIMEOUT(DATAWIDTH_TIMEOUT)
    ) u_tmo (
        .clk_i    (MEM_ACCESS_CTRL_CLOCK_50),
        .rst_i    (MEM_ACCESS_CTRL_RESET_InHigh),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mac_rd && mac_wr) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (mac_rd || mac_wr) begin
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = mac_addr;
                        wdata_d = mac_wdata;
                        we_d    = mac_wr;
                        req_d   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Ready takes priority over a timeout in the same cycle.
                if (mem_ready) begin
                    req_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_en = 1'b1;
                    if (expired) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge MEM_ACCESS_CTRL_CLOCK_50) begin
        if (MEM_ACCESS_CTRL_RESET_InHigh) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mac_ack   = (state_q == DONE);
    assign mac_err   = mac_ack && err_q;
    assign mac_rdata = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
